// File: rtl/detfreq.sv
// detfreq - tone-presence detector.
//
// Recovers the 8-bit chord from the 8 square-wave note lines. Each line has
// its own synchronizer, period counter and lock state machine. A chord bit is
// set after HITS consecutive in-range periods. It clears on a bad (short)
// period, or when no rising edge arrives within MAX_PER+1 cycles.
//
// Ports
//   clk        system clock, all state on the rising edge
//   rst_n      asynchronous active-low reset
//   freq[7:0]  note lines, asynchronous to clk, bit i = note i
//   chord[7:0] detected chord, bit i high = note i sounding
//   chord_chg  one-cycle pulse in the cycle after any chord bit changes
//
// Per-channel states
//   state     | meaning
//   ----------+--------------------------------------------------------------
//   ST_IDLE   | not armed; the next rising edge only arms the channel
//   ST_ARMED  | armed, counting consecutive legal periods (hit < HITS)
//   ST_LOCKED | HITS legal periods seen, chord bit set
//
// Parameter constraints: MAX_PER < 2^CNT_W-1 and HITS in 1..7.

module detfreq #(
   parameter int CNT_W   = 16,
   parameter int MIN_PER = 16,
   parameter int MAX_PER = 4096,
   parameter int HITS    = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] freq,
   output logic [7:0] chord,
   output logic       chord_chg
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ARMED  = 2'd1,
      ST_LOCKED = 2'd2
   } ch_state_t;

   localparam logic [CNT_W-1:0] CNT_SAT = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] MIN_C   = CNT_W'(MIN_PER);
   localparam logic [CNT_W-1:0] MAX_C   = CNT_W'(MAX_PER);
   localparam logic [CNT_W-1:0] TMO_C   = CNT_W'(MAX_PER + 1);
   localparam logic [2:0]       HITS_C  = 3'(HITS);

   logic [7:0] chord_nxt;
   logic       chg_q;

   genvar gi;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_ch
         // sync_q[0], sync_q[1]: synchronizer; sync_q[2]: previous synced level
         logic [2:0]       sync_q;
         logic             rise;
         logic             legal;
         logic             timeout;
         logic [CNT_W-1:0] cnt_q;
         logic [CNT_W-1:0] cnt_d;
         logic [2:0]       hit_q;
         logic [2:0]       hit_d;
         ch_state_t        state_q;
         ch_state_t        state_d;

         assign rise    = sync_q[1] & ~sync_q[2];
         // cnt_q holds the period P in the cycle the closing edge is seen
         assign legal   = (cnt_q >= MIN_C) && (cnt_q <= MAX_C);
         assign timeout = (cnt_q == TMO_C);

         assign chord_nxt[gi] = (state_d == ST_LOCKED);

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               sync_q  <= '0;
               cnt_q   <= '0;
               hit_q   <= '0;
               state_q <= ST_IDLE;
            end else begin
               sync_q  <= {sync_q[1:0], freq[gi]};
               cnt_q   <= cnt_d;
               hit_q   <= hit_d;
               state_q <= state_d;
            end
         end

         always_comb begin
            state_d = state_q;
            hit_d   = hit_q;
            cnt_d   = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_ONE;
            // restart at 1 so the count equals the period when the next edge lands
            if (rise) begin
               cnt_d = CNT_ONE;
            end

            case (state_q)
               ST_IDLE: begin
                  if (rise) begin
                     state_d = ST_ARMED;
                     hit_d   = '0;
                  end
               end
               ST_ARMED: begin
                  if (rise) begin
                     if (!legal) begin
                        hit_d = '0;
                     end else if (hit_q + 3'd1 >= HITS_C) begin
                        hit_d   = HITS_C;
                        state_d = ST_LOCKED;
                     end else begin
                        hit_d = hit_q + 3'd1;
                     end
                  end else if (timeout) begin
                     state_d = ST_IDLE;
                     hit_d   = '0;
                  end
               end
               ST_LOCKED: begin
                  // an edge landing on the timeout cycle is a period of
                  // MAX_PER+1, so it is rejected here and the channel re-arms
                  if (rise) begin
                     if (!legal) begin
                        state_d = ST_ARMED;
                        hit_d   = '0;
                     end
                  end else if (timeout) begin
                     state_d = ST_IDLE;
                     hit_d   = '0;
                  end
               end
               default: begin
                  state_d = ST_IDLE;
                  hit_d   = '0;
               end
            endcase
         end
      end
   endgenerate

   // chg_q marks the cycle chord is updated; chord_chg follows one cycle later
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chord     <= '0;
         chg_q     <= 1'b0;
         chord_chg <= 1'b0;
      end else begin
         chord     <= chord_nxt;
         chg_q     <= (chord_nxt != chord);
         chord_chg <= chg_q;
      end
   end

endmodule

// File: tb/tb_detfreq.sv
// Testbench for detfreq: table-driven period vectors, hand-written corner
// sequences and randomized note lines, all checked against an edge-history
// reference model.

module tb_detfreq;

   localparam int MIN_PER = 16;
   localparam int MAX_PER = 4096;
   localparam int HITS    = 2;

   logic       clk;
   logic       rst_n;
   logic [7:0] freq;
   logic [7:0] chord;
   logic       chord_chg;

   detfreq dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .freq      (freq),
      .chord     (chord),
      .chord_chg (chord_chg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int         checks = 0;
   int         errors = 0;
   int         cyc    = 0;
   int         rcnt   = 0;
   logic       chk_en = 1'b0;
   logic [7:0] fprev  = '0;
   int         pq [8][$];

   logic [7:0] act    = '0;
   logic       rnd_on = 1'b0;
   int         per [8];
   int         ph  [8];

   typedef struct {
      int         per;
      logic [7:0] exp_chord;
   } vec_t;

   vec_t vecs [9];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   // Chord bit i after clock m: the last edge taking effect by m is no more
   // than MAX_PER clocks old and the HITS periods ending at it are all legal.
   function automatic logic exp_bit(input int i, input int m);
      int k;
      int d;
      k = -1;
      for (int j = 0; j < pq[i].size(); j++) begin
         if (pq[i][j] <= m) k = j;
      end
      if (k < HITS) return 1'b0;
      if (m - pq[i][k] > MAX_PER) return 1'b0;
      for (int h = 0; h < HITS; h++) begin
         d = pq[i][k-h] - pq[i][k-h-1];
         if (d < MIN_PER || d > MAX_PER) return 1'b0;
      end
      return 1'b1;
   endfunction

   // Edge history: a rise sampled at clock n takes effect at clock n+2.
   initial begin
      forever begin
         @(posedge clk);
         cyc = cyc + 1;
         if (!rst_n) begin
            fprev = '0;
            rcnt  = 0;
            for (int i = 0; i < 8; i++) pq[i].delete();
         end else begin
            if (rcnt < 4) rcnt = rcnt + 1;
            for (int i = 0; i < 8; i++) begin
               if (freq[i] && !fprev[i]) begin
                  pq[i].push_back(cyc + 2);
                  if (pq[i].size() > 10) void'(pq[i].pop_front());
               end
            end
            fprev = freq;
         end
      end
   end

   task automatic model_check();
      logic [7:0] e0;
      logic [7:0] e1;
      logic [7:0] e2;
      logic       ec;
      for (int i = 0; i < 8; i++) begin
         e0[i] = exp_bit(i, cyc);
         e1[i] = exp_bit(i, cyc - 1);
         e2[i] = exp_bit(i, cyc - 2);
      end
      ec = (rcnt >= 2) && (e1 != e2);
      if (!rst_n) begin
         e0 = '0;
         ec = 1'b0;
      end
      chk("model_chord", 32'(chord), 32'(e0));
      chk("model_chg", 32'(chord_chg), 32'(ec));
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (chk_en) model_check();
      end
   end

   function automatic int pick_per();
      case ($urandom_range(0, 11))
         0:       return 3;
         1:       return 12;
         2:       return 15;
         3:       return 16;
         4:       return 17;
         5:       return 40;
         6:       return 100;
         7:       return 257;
         8:       return 1000;
         9:       return 4096;
         10:      return 4097;
         default: return 5000;
      endcase
   endfunction

   task automatic drive(input int n);
      for (int c = 0; c < n; c++) begin
         @(negedge clk);
         for (int i = 0; i < 8; i++) begin
            if (act[i]) begin
               freq[i] = (ph[i] < (per[i] + 1) / 2);
               ph[i]   = ph[i] + 1;
               if (ph[i] >= per[i]) begin
                  ph[i] = 0;
                  if (rnd_on && $urandom_range(0, 3) == 0) per[i] = pick_per();
               end
            end
         end
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      #1;
      rst_n  = 1'b0;
      freq   = '0;
      act    = '0;
      rnd_on = 1'b0;
      for (int i = 0; i < 8; i++) begin
         ph[i]  = 0;
         per[i] = 100;
      end
      repeat (3) @(negedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic lock_timeout(input logic hold);
      int c_lock;
      int c_fall;
      do_reset();
      act    = 8'h08;
      per[3] = 100;
      drive(203);
      chk("lock_early", 32'(chord), 32'h00);
      drive(1);
      chk("lock_ch3", 32'(chord), 32'h08);
      chk("lock_chg_lo", 32'(chord_chg), 32'h0);
      c_lock = cyc;
      drive(1);
      chk("lock_chg_pulse", 32'(chord_chg), 32'h1);
      drive(1);
      chk("lock_chg_end", 32'(chord_chg), 32'h0);
      act     = '0;
      freq[3] = hold;
      c_fall  = -1;
      for (int w = 0; w < 5000 && c_fall < 0; w++) begin
         @(negedge clk);
         if (chord[3] == 1'b0) c_fall = cyc;
      end
      if (c_fall < 0) begin
         chk("timeout_bound", 32'(chord), 32'h00);
      end else begin
         chk("timeout_delay", 32'(c_fall - c_lock), 32'd4097);
         chk("timeout_chg_lo", 32'(chord_chg), 32'h0);
         @(negedge clk);
         chk("timeout_chg_pulse", 32'(chord_chg), 32'h1);
         @(negedge clk);
         chk("timeout_chg_end", 32'(chord_chg), 32'h0);
      end
   endtask

   int pulses;

   initial begin
      vecs[0] = '{2,    8'h00};
      vecs[1] = '{10,   8'h00};
      vecs[2] = '{15,   8'h00};
      vecs[3] = '{16,   8'h01};
      vecs[4] = '{17,   8'h01};
      vecs[5] = '{100,  8'h01};
      vecs[6] = '{3000, 8'h01};
      vecs[7] = '{4096, 8'h01};
      vecs[8] = '{4097, 8'h00};

      rst_n = 1'b0;
      freq  = '0;
      for (int i = 0; i < 8; i++) begin
         per[i] = 100;
         ph[i]  = 0;
      end
      chk_en = 1'b1;

      // held in reset while the lines toggle
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         freq = 8'($urandom);
         chk("rst_chord", 32'(chord), 32'h00);
         chk("rst_chg", 32'(chord_chg), 32'h0);
      end

      // single-channel period table
      for (int v = 0; v < 9; v++) begin
         do_reset();
         act    = 8'h01;
         per[0] = vecs[v].per;
         drive(2 * vecs[v].per + 5);
         @(negedge clk);
         chk($sformatf("table_per%0d", vecs[v].per), 32'(chord), 32'(vecs[v].exp_chord));
      end

      lock_timeout(1'b0);
      lock_timeout(1'b1);

      // asynchronous reset while locked, then re-arm only on the first edge
      do_reset();
      act    = 8'h08;
      per[3] = 100;
      drive(204);
      chk("async_pre", 32'(chord), 32'h08);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_clr", 32'(chord), 32'h00);
      chk("async_chg", 32'(chord_chg), 32'h0);
      freq  = '0;
      ph[3] = 0;
      @(negedge clk);
      #1;
      rst_n = 1'b1;
      drive(104);
      chk("rearm_only", 32'(chord), 32'h00);
      drive(100);
      chk("relock", 32'(chord), 32'h08);

      // glitch on a locked channel, then recovery
      do_reset();
      act    = 8'h20;
      per[5] = 200;
      drive(405);
      chk("glitch_pre", 32'(chord), 32'h20);
      drive(195);
      per[5] = 10;
      drive(10);
      per[5] = 200;
      drive(5);
      chk("glitch_drop", 32'(chord), 32'h00);
      drive(400);
      chk("glitch_relock", 32'(chord), 32'h20);

      // eight channels, staggered periods
      do_reset();
      act = 8'hFF;
      for (int i = 0; i < 8; i++) per[i] = 20 * (i + 1);
      drive(490);
      chk("multi_all", 32'(chord), 32'hFF);

      // eight channels, identical period: one jump and one pulse
      do_reset();
      act = 8'hFF;
      for (int i = 0; i < 8; i++) per[i] = 50;
      drive(103);
      chk("same_pre", 32'(chord), 32'h00);
      drive(1);
      chk("same_all", 32'(chord), 32'hFF);
      pulses = int'(chord_chg);
      for (int c = 0; c < 5; c++) begin
         drive(1);
         pulses += int'(chord_chg);
      end
      chk("same_pulses", 32'(pulses), 32'd1);

      // randomized lines against the model
      do_reset();
      act    = 8'hFF;
      rnd_on = 1'b1;
      for (int i = 0; i < 8; i++) begin
         per[i] = pick_per();
         ph[i]  = $urandom_range(0, per[i] - 1);
      end
      drive(20000);

      @(negedge clk);
      chk_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
